ultrasonic_ranger_mc: RTL and testbench
=======================================

Name: ultrasonic_ranger_mc

Overview:
Multi-channel HC-SR04 ranging controller. It fires sensors round-robin, either on a free-running period timer or on a manual request. It measures each echo pulse with a timeout, converts the pulse to centimetres using a fixed-point reciprocal, and keeps a per-channel proximity flag with hysteresis. This flag drives the buzzer. It replaces the single-channel ranger and the separate 50 ms refresher in the sensor path.

Parameters:
CHANNELS, 2, number of sensors, 1..8
TRIGGER_CYCLES, 120, trig pulse width in clk cycles (10 us at 12 MHz)
TIMEOUT_CYCLES, 360000, maximum wait for echo rise, and maximum echo width (30 ms)
PERIOD_CYCLES, 600000, auto-mode ping interval (50 ms)
RAW_W, 24, width of the raw echo count
CM_W, 16, width of the distance in cm
CM_SCALE, 94, Q16 cm-per-cycle factor, equal to round(34300*65536/(2*12e6))
NEAR_CM, 5, near flag sets at or below this distance
HYST_CM, 2, near flag clears at or above NEAR_CM+HYST_CM

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  auto mode: periodic pings while high
measure  in  1  manual single-ping request, sampled in IDLE
echo  in  CHANNELS  raw echo inputs (asynchronous)
trig  out  CHANNELS  one-hot trigger outputs
ready  out  1  high only in IDLE
cur_ch  out  $clog2(CHANNELS) (min 1)  channel being or next to be measured
dist_valid  out  1  one-cycle result strobe
dist_ch  out  $clog2(CHANNELS) (min 1)  channel of the current result
dist_raw  out  RAW_W  echo width in clk cycles
dist_cm  out  CM_W  converted distance
timeout  out  1  result is a timeout, qualified by dist_valid
overrun  out  1  one-cycle pulse: a period tick arrived while busy and was dropped
near  out  CHANNELS  per-channel proximity flags
buzzer  out  1  OR of near

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. The period counter, cur_ch and synchronizers clear to 0. trig drops immediately. If reset occurs mid-ping, that measurement is discarded and no dist_valid is issued.
- echo goes through a 2-flop synchronizer (echo_s). Both edges are delayed equally, so width is preserved.
- Period timer runs only while en=1. It counts 0..PERIOD_CYCLES-1 and wraps. The tick is the cycle in which the count equals 0 with en=1. While en=0 the counter is held at 0, and the first tick occurs in the first cycle of en=1.
- start = (measure | tick) in IDLE. If tick occurs outside IDLE, it is dropped and overrun pulses. If measure occurs outside IDLE, it is ignored silently.
- FSM states:
  - IDLE: when start is seen, go to TRIGGER. cur_ch is already stable.
  - TRIGGER: trig[cur_ch]=1 for exactly TRIGGER_CYCLES cycles, then go to WAIT_ECHO. The wait counter clears.
  - WAIT_ECHO: when echo_s[cur_ch]=1, set raw to 1 and go to COUNT. If the wait counter reaches TIMEOUT_CYCLES, go to DONE with a timeout.
  - COUNT: while echo_s=1, raw increments. When echo_s=0, go to DONE. If raw reaches TIMEOUT_CYCLES, go to DONE with a timeout. A stuck-high echo therefore terminates.
  - DONE: lasts 1 cycle, then returns to IDLE. In IDLE, cur_ch advances (wrapping CHANNELS-1 to 0).
- Result: registered at the end of DONE, so dist_valid is high in the first IDLE cycle. That is 2 cycles after echo_s falls.
  - dist_raw = raw, which equals the echo width W in cycles.
  - dist_cm = (raw*CM_SCALE)>>16, truncated and saturated to 2^CM_W-1.
  - On timeout: dist_raw=0, dist_cm=2^CM_W-1, timeout=1.
  - dist_ch = the channel that was measured. Outputs hold until the next result.
- The product width is RAW_W+8 bits or more. No divider is used.
- near[ch] updates only with dist_valid for that channel:
  - set if dist_cm<=NEAR_CM
  - clear if dist_cm>=NEAR_CM+HYST_CM or on timeout
  - otherwise hold
  - buzzer is a registered OR of near, so it follows near by one cycle.
- If en and measure arrive together, only one ping is issued.

Test Plan:
1. Reset, then measure pulse with CHANNELS=2 on ch0, echo high 7000 cycles -> trig[0] high exactly 120 cycles, dist_raw=7000, dist_cm=10, dist_ch=0, timeout=0, cur_ch becomes 1.
2. Ping ch1 with echo widths 2800 (cm=4), then 4200 (cm=6), then 4900 (cm=7) -> near[1] goes 1, stays 1, then goes 0; buzzer tracks near one cycle later.
3. No echo on ch0 -> after 360000 WAIT cycles dist_valid arrives with timeout=1, dist_cm=0xFFFF and near[0]=0. Echo stuck high -> timeout after 360000 counted cycles.
4. en=1 with short echoes -> ticks every 600000 cycles, channels alternate 0,1,0. Then set PERIOD_CYCLES=1000 with a 3000-cycle echo -> overrun pulses and ticks are dropped.
5. Assert rst during COUNT -> trig, near, buzzer and dist_valid all 0 with no stale result. The next ping after release measures ch0 correctly.
6. measure and tick in the same cycle, and measure during TRIGGER -> exactly one ping and one dist_valid.

Source files
------------

// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc
// Multi-channel HC-SR04 ranging controller. Sensors are pinged round-robin,
// either from a free-running period timer (en=1) or from a manual request
// (measure). Each echo pulse is measured against a timeout, converted to
// centimetres with a Q16 reciprocal multiply, and fed into a per-channel
// proximity flag with hysteresis that drives the buzzer.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         auto mode, periodic pings while high
//   measure    manual single-ping request, only honoured in IDLE
//   echo       raw echo inputs, one per sensor (asynchronous)
//   trig       one-hot trigger outputs
//   ready      high only while the controller is idle
//   cur_ch     channel being measured, or the next one to be measured
//   dist_valid one-cycle strobe, result fields below are valid
//   dist_ch    channel of the current result
//   dist_raw   echo width in clk cycles (0 on timeout)
//   dist_cm    distance in cm, saturated (all ones on timeout)
//   timeout    result is a timeout, qualified by dist_valid
//   overrun    one-cycle pulse: a period tick was dropped while busy
//   near       per-channel proximity flags
//   buzzer     registered OR of near
module ultrasonic_ranger_mc #(
    parameter int CHANNELS       = 2,
    parameter int TRIGGER_CYCLES = 120,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int PERIOD_CYCLES  = 600000,
    parameter int RAW_W          = 24,
    parameter int CM_W           = 16,
    parameter int CM_SCALE       = 94,
    parameter int NEAR_CM        = 5,
    parameter int HYST_CM        = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic                                          measure,
    input  logic [CHANNELS-1:0]                           echo,
    output logic [CHANNELS-1:0]                           trig,
    output logic                                          ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cur_ch,
    output logic                                          dist_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] dist_ch,
    output logic [RAW_W-1:0]                              dist_raw,
    output logic [CM_W-1:0]                               dist_cm,
    output logic                                          timeout,
    output logic                                          overrun,
    output logic [CHANNELS-1:0]                           near,
    output logic                                          buzzer
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TRG_W  = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_W  = (TRG_W > TMO_W) ? TRG_W : TMO_W;
    // Scale factor gets at least 8 bits so the product never truncates.
    localparam int SC_W   = ($clog2(CM_SCALE + 1) > 8) ? $clog2(CM_SCALE + 1) : 8;
    localparam int PROD_W = RAW_W + SC_W;

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TRG_LAST  = CNT_W'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RAW_W-1:0]  RAW_MAX   = RAW_W'(TIMEOUT_CYCLES);
    localparam logic [CM_W-1:0]   CM_ALL1   = {CM_W{1'b1}};
    localparam logic [PROD_W-1:0] CM_MAX_P  = PROD_W'(CM_ALL1);
    localparam logic [CM_W-1:0]   NEAR_SET  = CM_W'(NEAR_CM);
    localparam logic [CM_W-1:0]   NEAR_CLR  = CM_W'(NEAR_CM + HYST_CM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_ECHO,
        S_COUNT,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [RAW_W-1:0]    raw_reg;
    logic                to_flag_reg;
    logic [CH_W-1:0]     cur_ch_reg;
    logic [CHANNELS-1:0] trig_reg;
    logic                ready_reg;
    logic                dist_valid_reg;
    logic [CH_W-1:0]     dist_ch_reg;
    logic [RAW_W-1:0]    dist_raw_reg;
    logic [CM_W-1:0]     dist_cm_reg;
    logic                timeout_reg;
    logic                overrun_reg;
    logic                buzzer_reg;
    logic [PER_W-1:0]    per_reg;

    logic [CHANNELS-1:0] echo_s;
    logic [CHANNELS-1:0] near_vec;
    logic                tick;
    logic                echo_sel;
    logic [CH_W-1:0]     cur_ch_next;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   cm_full;
    logic [CM_W-1:0]     cm_sat;
    logic [CM_W-1:0]     res_cm;

    // Per-channel echo synchronizer and proximity flag.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic meta_reg;
        logic sync_reg;
        logic near_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= echo[gi];
                sync_reg <= meta_reg;
            end
        end

        // Updated at the same edge that raises dist_valid for this channel.
        // Between the two thresholds the previous state is kept.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                near_reg <= 1'b0;
            end else if (state_reg == S_DONE && cur_ch_reg == CH_W'(gi)) begin
                if (to_flag_reg || res_cm >= NEAR_CLR) begin
                    near_reg <= 1'b0;
                end else if (res_cm <= NEAR_SET) begin
                    near_reg <= 1'b1;
                end
            end
        end

        assign echo_s[gi]   = sync_reg;
        assign near_vec[gi] = near_reg;
    end

    // Period timer: held at 0 while disabled, so enabling fires at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_reg <= '0;
        end else if (!en) begin
            per_reg <= '0;
        end else if (per_reg == PER_LAST) begin
            per_reg <= '0;
        end else begin
            per_reg <= per_reg + PER_W'(1);
        end
    end

    assign tick        = en && (per_reg == '0);
    assign echo_sel    = echo_s[cur_ch_reg];
    assign cur_ch_next = (cur_ch_reg == CH_LAST) ? '0 : cur_ch_reg + CH_W'(1);

    // cm = (raw * CM_SCALE) >> 16, truncated, then clamped to the output width.
    assign prod    = PROD_W'(raw_reg) * PROD_W'(CM_SCALE);
    assign cm_full = prod >> 16;
    assign cm_sat  = (cm_full > CM_MAX_P) ? CM_ALL1 : cm_full[CM_W-1:0];
    assign res_cm  = to_flag_reg ? CM_ALL1 : cm_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            raw_reg        <= '0;
            to_flag_reg    <= 1'b0;
            cur_ch_reg     <= '0;
            trig_reg       <= '0;
            ready_reg      <= 1'b0;
            dist_valid_reg <= 1'b0;
            dist_ch_reg    <= '0;
            dist_raw_reg   <= '0;
            dist_cm_reg    <= '0;
            timeout_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            dist_valid_reg <= 1'b0;
            // A tick that lands while a ping is in flight is lost.
            overrun_reg    <= tick && (state_reg != S_IDLE);

            case (state_reg)
                S_IDLE: begin
                    ready_reg <= 1'b1;
                    if (measure || tick) begin
                        state_reg   <= S_TRIGGER;
                        trig_reg    <= CHANNELS'(1) << cur_ch_reg;
                        cnt_reg     <= '0;
                        raw_reg     <= '0;
                        to_flag_reg <= 1'b0;
                        ready_reg   <= 1'b0;
                    end
                end

                S_TRIGGER: begin
                    if (cnt_reg == TRG_LAST) begin
                        trig_reg  <= '0;
                        cnt_reg   <= '0;
                        state_reg <= S_WAIT_ECHO;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_WAIT_ECHO: begin
                    if (echo_sel) begin
                        // The first high sample already counts as one cycle.
                        raw_reg   <= RAW_W'(1);
                        state_reg <= S_COUNT;
                    end else if (cnt_reg == WAIT_LAST) begin
                        to_flag_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_COUNT: begin
                    if (!echo_sel) begin
                        state_reg <= S_DONE;
                    end else if (raw_reg == RAW_MAX) begin
                        // Stuck-high echo: give up after the maximum width.
                        to_flag_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        raw_reg <= raw_reg + RAW_W'(1);
                    end
                end

                S_DONE: begin
                    state_reg      <= S_IDLE;
                    ready_reg      <= 1'b1;
                    dist_valid_reg <= 1'b1;
                    dist_ch_reg    <= cur_ch_reg;
                    dist_raw_reg   <= to_flag_reg ? '0 : raw_reg;
                    dist_cm_reg    <= res_cm;
                    timeout_reg    <= to_flag_reg;
                    cur_ch_reg     <= cur_ch_next;
                end

                default: begin
                    state_reg <= S_IDLE;
                    trig_reg  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzzer_reg <= 1'b0;
        end else begin
            buzzer_reg <= |near_vec;
        end
    end

    assign trig       = trig_reg;
    assign ready      = ready_reg;
    assign cur_ch     = cur_ch_reg;
    assign dist_valid = dist_valid_reg;
    assign dist_ch    = dist_ch_reg;
    assign dist_raw   = dist_raw_reg;
    assign dist_cm    = dist_cm_reg;
    assign timeout    = timeout_reg;
    assign overrun    = overrun_reg;
    assign near       = near_vec;
    assign buzzer     = buzzer_reg;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
`timescale 1ns/1ps
module tb_ultrasonic_ranger_mc;

    localparam int TRG = 120;
    localparam int TMO = 7500;
    localparam int PER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        measure;
    logic [1:0]  echo;
    logic [1:0]  trig;
    logic        ready;
    logic [0:0]  cur_ch;
    logic        dist_valid;
    logic [0:0]  dist_ch;
    logic [23:0] dist_raw;
    logic [15:0] dist_cm;
    logic        timeout;
    logic        overrun;
    logic [1:0]  near;
    logic        buzzer;

    ultrasonic_ranger_mc #(
        .CHANNELS(2), .TRIGGER_CYCLES(TRG), .TIMEOUT_CYCLES(TMO),
        .PERIOD_CYCLES(PER), .RAW_W(24), .CM_W(16), .CM_SCALE(94),
        .NEAR_CM(5), .HYST_CM(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .measure(measure), .echo(echo),
        .trig(trig), .ready(ready), .cur_ch(cur_ch), .dist_valid(dist_valid),
        .dist_ch(dist_ch), .dist_raw(dist_raw), .dist_cm(dist_cm),
        .timeout(timeout), .overrun(overrun), .near(near), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event counters, sampled on the inactive edge.
    int dv_cnt = 0;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    logic [1:0] prev_trig = 2'b00;
    always @(negedge clk) begin
        if (dist_valid === 1'b1) dv_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (trig != 2'b00 && prev_trig == 2'b00) rise_cnt++;
        prev_trig = trig;
    end

    typedef struct {
        int ch;
        int width;      // 0 = no echo, -1 = echo stuck high
        int exp_raw;
        int exp_cm;
        int exp_to;
        int exp_near;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(input int max_cyc, output int ch);
        int waited = 0;
        ch = -1;
        while (trig == 2'b00 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        if (trig == 2'b01) ch = 0;
        else if (trig == 2'b10) ch = 1;
        else if (trig != 2'b00) ch = -2;
    endtask

    task automatic measure_trig(output int width);
        width = 0;
        while (trig != 2'b00 && width < 1000) begin
            @(negedge clk);
            width++;
        end
    endtask

    task automatic drive_echo(input int ch, input int width);
        repeat (5) @(negedge clk);
        if (width != 0) begin
            echo[ch] = 1'b1;
            if (width > 0) begin
                repeat (width) @(negedge clk);
                echo[ch] = 1'b0;
            end
        end
    endtask

    task automatic wait_dv(input int max_cyc, output bit ok);
        int waited = 0;
        ok = 1'b0;
        while (dist_valid !== 1'b1 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        ok = (dist_valid === 1'b1);
    endtask

    task automatic pulse_measure();
        @(negedge clk);
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ch;
        int tw;
        bit ok;
        pulse_measure();
        wait_trig(10, ch);
        check({tag, " trig_ch"}, ch, v.ch);
        measure_trig(tw);
        check({tag, " trig_width"}, tw, TRG);
        drive_echo(v.ch, v.width);
        wait_dv(TMO + 500, ok);
        check({tag, " dist_valid_seen"}, int'(ok), 1);
        check({tag, " dist_ch"}, int'(dist_ch), v.ch);
        check({tag, " dist_raw"}, int'(dist_raw), v.exp_raw);
        check({tag, " dist_cm"}, int'(dist_cm), v.exp_cm);
        check({tag, " timeout"}, int'(timeout), v.exp_to);
        check({tag, " near"}, int'(near), v.exp_near);
        check({tag, " cur_ch"}, int'(cur_ch), (v.ch + 1) % 2);
        if (v.width < 0) echo[v.ch] = 1'b0;
        @(negedge clk);
        check({tag, " dist_valid_one_cycle"}, int'(dist_valid), 0);
        check({tag, " buzzer"}, int'(buzzer), int'(v.exp_near != 0));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int ch;
        int tw;
        bit ok;
        int dv_base;
        int ovr_base;
        int rise_base;
        longint t_rise[4];
        vec_t v5;

        // ch, width, raw, cm, timeout, near (after the result)
        vecs[0]  = '{0, 7000, 7000, 10, 0, 0};
        vecs[1]  = '{1, 2800, 2800, 4, 0, 2};
        vecs[2]  = '{0, 4900, 4900, 7, 0, 2};
        vecs[3]  = '{1, 4200, 4200, 6, 0, 2};
        vecs[4]  = '{0, 4900, 4900, 7, 0, 2};
        vecs[5]  = '{1, 4900, 4900, 7, 0, 0};
        vecs[6]  = '{0, 300, 300, 0, 0, 1};
        vecs[7]  = '{1, 4900, 4900, 7, 0, 1};
        vecs[8]  = '{0, 0, 0, 65535, 1, 0};
        vecs[9]  = '{1, -1, 0, 65535, 1, 0};
        vecs[10] = '{0, 3486, 3486, 5, 0, 1};
        vecs[11] = '{1, 4200, 4200, 6, 0, 1};

        rst = 1'b1;
        en = 1'b0;
        measure = 1'b0;
        echo = 2'b00;
        repeat (3) @(negedge clk);
        check("reset trig", int'(trig), 0);
        check("reset ready", int'(ready), 0);
        check("reset dist_valid", int'(dist_valid), 0);
        check("reset cur_ch", int'(cur_ch), 0);
        check("reset near", int'(near), 0);
        check("reset buzzer", int'(buzzer), 0);
        check("reset dist_cm", int'(dist_cm), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle ready", int'(ready), 1);

        // Manual pings, hysteresis and timeouts from the vector table.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            $display("vec%0d ch=%0d width=%0d raw=%0d cm=%0d to=%0d near=%b",
                     i, vecs[i].ch, vecs[i].width, dist_raw, dist_cm, timeout, near);
        end

        // Auto mode: three short pings one period apart, then a long echo
        // that overlaps three ticks.
        ovr_base = ovr_cnt;
        rise_base = rise_cnt;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_trig(PER + 100, ch);
            t_rise[k] = $time;
            check($sformatf("auto%0d trig_ch", k), ch, k % 2);
            if (k > 0) check($sformatf("auto%0d interval", k),
                             int'((t_rise[k] - t_rise[k-1]) / 10), PER);
            measure_trig(tw);
            drive_echo(k % 2, (k == 3) ? 3000 : 100);
            wait_dv(4000, ok);
            check($sformatf("auto%0d dist_valid_seen", k), int'(ok), 1);
            check($sformatf("auto%0d dist_ch", k), int'(dist_ch), k % 2);
            if (k == 2) check("auto overrun_none", ovr_cnt - ovr_base, 0);
            $display("auto%0d ch=%0d raw=%0d cm=%0d", k, ch, dist_raw, dist_cm);
        end
        en = 1'b0;
        repeat (1200) @(negedge clk);
        check("auto overrun_count", ovr_cnt - ovr_base, 3);
        check("auto trig_rises", rise_cnt - rise_base, 4);
        check("auto near", int'(near), 3);
        check("auto buzzer", int'(buzzer), 1);

        // Reset in the middle of an echo count.
        pulse_measure();
        wait_trig(10, ch);
        check("rstcount trig_ch", ch, 0);
        measure_trig(tw);
        repeat (5) @(negedge clk);
        echo[0] = 1'b1;
        repeat (50) @(negedge clk);
        dv_base = dv_cnt;
        rst = 1'b1;
        #1;
        check("rstcount trig", int'(trig), 0);
        check("rstcount near", int'(near), 0);
        check("rstcount buzzer", int'(buzzer), 0);
        check("rstcount dist_valid", int'(dist_valid), 0);
        check("rstcount ready", int'(ready), 0);
        echo[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstcount no_stale_result", dv_cnt - dv_base, 0);
        check("rstcount cur_ch", int'(cur_ch), 0);
        v5 = '{0, 2800, 2800, 4, 0, 1};
        run_vec(v5, "after_rst");
        $display("after_rst raw=%0d cm=%0d near=%b", dist_raw, dist_cm, near);

        // Tick and measure in the same cycle: a single ping.
        dv_base = dv_cnt;
        rise_base = rise_cnt;
        @(negedge clk);
        en = 1'b1;
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
        wait_trig(10, ch);
        check("coincide trig_ch", ch, 1);
        measure_trig(tw);
        drive_echo(1, 100);
        wait_dv(500, ok);
        en = 1'b0;
        check("coincide dist_valid_seen", int'(ok), 1);
        repeat (50) @(negedge clk);
        check("coincide pings", rise_cnt - rise_base, 1);
        check("coincide results", dv_cnt - dv_base, 1);
        $display("coincide ch=%0d raw=%0d", dist_ch, dist_raw);

        // measure while the trigger is active is ignored.
        dv_base = dv_cnt;
        rise_base = rise_cnt;
        pulse_measure();
        wait_trig(10, ch);
        check("busy_measure trig_ch", ch, 0);
        measure = 1'b1;
        repeat (3) @(negedge clk);
        measure = 1'b0;
        measure_trig(tw);
        drive_echo(0, 100);
        wait_dv(500, ok);
        check("busy_measure dist_valid_seen", int'(ok), 1);
        repeat (300) @(negedge clk);
        check("busy_measure pings", rise_cnt - rise_base, 1);
        check("busy_measure results", dv_cnt - dv_base, 1);
        check("busy_measure overrun", ovr_cnt - ovr_base, 3);
        $display("busy_measure ch=%0d raw=%0d", dist_ch, dist_raw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
